bit_residue_tracker: RTL
========================

Name: bit_residue_tracker

Overview:
- Serial bit-stream classifier and parametrised successor of the even/odd 0s/1s tracker.
- Keeps running counts of received 1s and 0s modulo MOD; MOD=2 reproduces the even/odd flags.
- Optional windowed mode snapshots both residues every WIN accepted bits and restarts counting.
- Sits behind a serial receiver or shift register in the pattern/parity checking path.

Parameters:
- MOD, 2, modulus for both residues; legal range 2..256.
- WIN, 8, window length in accepted bits for windowed mode; legal range 1..65535.
- RW, derived = $clog2(MOD), residue width; not overridable.
- CW, derived = $clog2(WIN+1), window bit-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in  input  1  serial data bit.
- in_valid  input  1  bit is accepted on a rising clk edge when 1.
- clr  input  1  synchronous clear of running state.
- mode  input  1  0 = running, 1 = windowed.
- ones_res  output  RW  count of accepted 1s mod MOD.
- zeros_res  output  RW  count of accepted 0s mod MOD.
- ones_mod0  output  1  ones_res==0; the "even1" flag when MOD=2.
- zeros_mod0  output  1  zeros_res==0; the "even0" flag when MOD=2.
- win_ones  output  RW  ones residue snapshot of the last completed window.
- win_zeros  output  RW  zeros residue snapshot of the last completed window.
- win_done  output  1  one-cycle pulse when a window completes.

Behaviour:
- Reset (rst=0, async, any time):
  - ones_res, zeros_res, win_ones, win_zeros, bit counter and win_done all go to 0.
  - ones_mod0 and zeros_mod0 go to 1, because a zero count is divisible.
  - Reset mid-window discards the partial window.
- All outputs are registered. An accepted bit is reflected on the outputs in the cycle after the edge that sampled it (latency 1).
- Accept (in_valid=1, clr=0):
  - in=1: ones_res <= (ones_res==MOD-1) ? 0 : ones_res+1.
  - in=0: zeros_res is updated the same way.
  - The other residue holds.
  - Residues wrap at MOD-1 to 0, with no overflow state.
- in_valid=0: all state holds; win_done <= 0.
- ones_mod0 and zeros_mod0 are registered together with the residues and are always consistent with them.
- Running mode (mode=0): the bit counter is held at 0; win_* outputs hold their last values; win_done stays 0.
- Windowed mode (mode=1):
  - The bit counter increments on each accepted bit.
  - When a bit is accepted with counter==WIN-1:
    - win_ones and win_zeros load the residues including that bit.
    - win_done=1 for exactly the next cycle.
    - ones_res, zeros_res and the counter all restart at 0 (mod0 flags = 1).
  - WIN=1: every accepted bit completes a window; win_done stays high across back-to-back accepted bits.
- clr=1 has priority over in_valid: residues and counter go to 0, win_done <= 0, win_ones and win_zeros hold. A bit presented in the same cycle is dropped.
- mode change: the counter is cleared on the edge where mode differs from its registered previous value. Residues are not cleared. Windows are counted from the first accepted bit after entering windowed mode.
- Input constraint: in, in_valid, clr and mode are synchronous to clk. in is don't-care when in_valid=0.

Test Plan:
- Reset/defaults: assert rst=0 mid-stream with MOD=2 -> outputs immediately read 0/0, mod0 flags 1/1, win_done 0.
- Legacy even/odd, MOD=2, mode=0, sequence 1,0,1,0,0,1,1,0,0,1,0,0,1 (6 ones, 7 zeros) -> ones_res=0, ones_mod0=1, zeros_res=1, zeros_mod0=0. Check per-bit flags track the parity after each bit with 1-cycle latency.
- Modulus wrap, MOD=3, same sequence -> ones_res=0, zeros_res=1. Intermediate check after 4 ones: ones_res=1.
- Windowed, MOD=3, WIN=8, mode=1, same sequence:
  - After bit 8: win_done pulses once; win_ones=1, win_zeros=1 (4/4 mod 3); running residues restart at 0.
  - After bit 13: ones_res=2, zeros_res=0, no second pulse.
- clr and in_valid gaps: in_valid=0 for 3 cycles mid-window -> no state change. clr=1 together with in_valid=1, in=1 -> residues 0, bit dropped, win_ones/win_zeros unchanged.
- Edge configs: WIN=1 and MOD=2 with stream 1,1,0 -> win_done high 3 consecutive cycles, win_ones=1,1,0, win_zeros=0,0,1.

Source files
------------

// File: rtl/bit_residue_tracker.sv
// rtl/bit_residue_tracker.sv - serial bit-stream ones/zeros residue tracker with optional windowed snapshots
module bit_residue_tracker #(
    parameter int MOD = 2,
    parameter int WIN = 8,
    localparam int RW = $clog2(MOD),
    localparam int CW = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in,
    input  logic          in_valid,
    input  logic          clr,
    input  logic          mode,
    output logic [RW-1:0] ones_res,
    output logic [RW-1:0] zeros_res,
    output logic          ones_mod0,
    output logic          zeros_mod0,
    output logic [RW-1:0] win_ones,
    output logic [RW-1:0] win_zeros,
    output logic          win_done
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          mode_q;
    logic          win_active;
    logic [RW-1:0] ones_step;
    logic [RW-1:0] zeros_step;
    logic [RW-1:0] ones_nx;
    logic [RW-1:0] zeros_nx;
    logic [RW-1:0] win_ones_nx;
    logic [RW-1:0] win_zeros_nx;
    logic          win_done_nx;

    // Windows only count while mode has been stable high; the edge that
    // changes mode restarts the bit counter without touching the residues.
    assign win_active = mode & mode_q;

    // Residue increment with wrap at MOD-1 back to zero.
    always_comb begin
        ones_step  = (ones_res  == RW'(MOD - 1)) ? '0 : ones_res  + RW'(1);
        zeros_step = (zeros_res == RW'(MOD - 1)) ? '0 : zeros_res + RW'(1);
    end

    // Next-state selection: clear beats accept, window completion restarts counting.
    always_comb begin
        ones_nx      = ones_res;
        zeros_nx     = zeros_res;
        cnt_nx       = win_active ? cnt : '0;
        win_ones_nx  = win_ones;
        win_zeros_nx = win_zeros;
        win_done_nx  = 1'b0;
        if (clr) begin
            ones_nx  = '0;
            zeros_nx = '0;
            cnt_nx   = '0;
        end else if (in_valid) begin
            if (in) begin
                ones_nx = ones_step;
            end else begin
                zeros_nx = zeros_step;
            end
            if (win_active) begin
                if (cnt == CW'(WIN - 1)) begin
                    win_ones_nx  = ones_nx;
                    win_zeros_nx = zeros_nx;
                    win_done_nx  = 1'b1;
                    ones_nx      = '0;
                    zeros_nx     = '0;
                    cnt_nx       = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
        end
    end

    // State and output registers; the mod0 flags are derived from the same next values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_res   <= '0;
            zeros_res  <= '0;
            ones_mod0  <= 1'b1;
            zeros_mod0 <= 1'b1;
            win_ones   <= '0;
            win_zeros  <= '0;
            win_done   <= 1'b0;
            cnt        <= '0;
            mode_q     <= 1'b0;
        end else begin
            ones_res   <= ones_nx;
            zeros_res  <= zeros_nx;
            ones_mod0  <= (ones_nx == '0);
            zeros_mod0 <= (zeros_nx == '0);
            win_ones   <= win_ones_nx;
            win_zeros  <= win_zeros_nx;
            win_done   <= win_done_nx;
            cnt        <= cnt_nx;
            mode_q     <= mode;
        end
    end

endmodule
